// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch/unescape front end.
// Prefix decode helper maps a byte to its flag bit.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_PREFIX = 2'd0,
    S_BODY   = 2'd1,
    S_ERROR  = 2'd2
  } state_e;

  localparam logic [7:0] PFX_OPSIZE   = 8'h66;
  localparam logic [7:0] PFX_ADDRSIZE = 8'h67;
  localparam logic [7:0] PFX_LOCK     = 8'hF0;
  localparam logic [7:0] PFX_REPNE    = 8'hF2;
  localparam logic [7:0] PFX_REP      = 8'hF3;
  localparam logic [7:0] ESCAPE_0F    = 8'h0F;

  typedef struct packed {
    logic opsize;
    logic addrsize;
    logic lock;
    logic rep;
    logic repne;
    logic esc;
  } flags_t;

  // All-zero result means the byte is not a legacy prefix
  function automatic flags_t pfx_flag(input logic [7:0] b);
    flags_t f;
    f = '0;
    unique case (1'b1)
      (b == PFX_OPSIZE):   f.opsize   = 1'b1;
      (b == PFX_ADDRSIZE): f.addrsize = 1'b1;
      (b == PFX_LOCK):     f.lock     = 1'b1;
      (b == PFX_REPNE):    f.repne    = 1'b1;
      (b == PFX_REP):      f.rep      = 1'b1;
      default:             f = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/fetch_unescape_byte_queue.sv
// Circular byte queue: single-byte push, variable pop,
// and a WINDOW-byte read port starting at the head.
module byte_queue
  import fetch_pkg::*;
#(
  parameter int DEPTH  = 16,
  parameter int WINDOW = 11
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clr,
  input  logic                      push,
  input  logic [7:0]                push_byte,
  input  logic [3:0]                pop_len,
  output logic [$clog2(DEPTH):0]    count,
  output logic [8*WINDOW-1:0]       window
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [7:0]    mem_d [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] tail;

  always_comb begin
    tail    = head_q + count_q[AW-1:0];
    mem_d   = mem_q;
    head_d  = head_q + AW'(pop_len);
    count_d = count_q + CW'(push) - CW'(pop_len);
    if (clr) begin
      head_d  = '0;
      count_d = '0;
    end else if (push) begin
      mem_d[tail] = push_byte;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      head_q  <= head_d;
      count_q <= count_d;
      mem_q   <= mem_d;
    end
  end

  always_comb begin
    window = '0;
    for (int k = 0; k < WINDOW; k++)
      window[8*k +: 8] = mem_q[head_q + AW'(k)];
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_unescape.sv
// Fetch front end: strips legacy prefixes and 0F escape into flags.
// Optional retired-instruction counter: FETCH_INSTR_COUNT_EN.
module fetch_unescape
  import fetch_pkg::*;
#(
  parameter int DEPTH        = 16,
  parameter int WINDOW       = 11,
  parameter int MAX_PREFIXES = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            in_byte,
  output logic                  out_valid,
  input  logic                  out_ready,
  input  logic [3:0]            consume_len,
  output logic [8*WINDOW-1:0]   unescaped_instr,
  output logic                  prefix_operand_16bit,
  output logic                  prefix_address_16bit,
  output logic                  prefix_lock,
  output logic                  prefix_rep,
  output logic                  prefix_repne,
  output logic                  is_escaped,
  output logic                  fetch_error,
  output logic [31:0]           instr_count
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int PW = $clog2(MAX_PREFIXES + 1);

  state_e        state_q, state_d;
  flags_t        flags_q, flags_d;
  logic [PW-1:0] pfx_q, pfx_d;
  logic [CW-1:0] q_count;
  logic [3:0]    pop_len;
  logic          push;
  logic          hs;
  logic          legal_len;
  logic [7:0]    head;
  flags_t        head_pfx;

  assign in_ready  = (q_count < CW'(DEPTH)) && !flush;
  assign push      = in_valid && in_ready;
  assign out_valid = (state_q == S_BODY) && (q_count >= CW'(WINDOW));
  assign hs        = out_valid && out_ready;
  assign legal_len = (consume_len != 4'd0) && (consume_len <= 4'(WINDOW));
  assign head      = unescaped_instr[7:0];
  assign head_pfx  = pfx_flag(head);

  byte_queue #(
    .DEPTH  (DEPTH),
    .WINDOW (WINDOW)
  ) u_queue (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (flush),
    .push      (push),
    .push_byte (in_byte),
    .pop_len   (pop_len),
    .count     (q_count),
    .window    (unescaped_instr)
  );

  always_comb begin
    state_d = state_q;
    flags_d = flags_q;
    pfx_d   = pfx_q;
    pop_len = 4'd0;
    if (flush) begin
      state_d = S_PREFIX;
      flags_d = '0;
      pfx_d   = '0;
    end else begin
      unique case (state_q)
        S_PREFIX: begin
          if (q_count != '0) begin
            if (head_pfx != '0) begin
              if (pfx_q == PW'(MAX_PREFIXES)) begin
                state_d = S_ERROR;
              end else begin
                pop_len = 4'd1;
                pfx_d   = pfx_q + PW'(1);
                flags_d = flags_q | head_pfx;
              end
            end else if (head == ESCAPE_0F) begin
              pop_len     = 4'd1;
              flags_d.esc = 1'b1;
              state_d     = S_BODY;
            end else begin
              state_d = S_BODY;
            end
          end
        end
        S_BODY: begin
          if (hs) begin
            if (legal_len) begin
              pop_len = consume_len;
              flags_d = '0;
              pfx_d   = '0;
              state_d = S_PREFIX;
            end else begin
              state_d = S_ERROR;
            end
          end
        end
        S_ERROR: state_d = S_ERROR;
        default: state_d = S_PREFIX;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_PREFIX;
      flags_q <= '0;
      pfx_q   <= '0;
    end else begin
      state_q <= state_d;
      flags_q <= flags_d;
      pfx_q   <= pfx_d;
    end
  end

  assign prefix_operand_16bit = flags_q.opsize;
  assign prefix_address_16bit = flags_q.addrsize;
  assign prefix_lock          = flags_q.lock;
  assign prefix_rep           = flags_q.rep;
  assign prefix_repne         = flags_q.repne;
  assign is_escaped           = flags_q.esc;
  assign fetch_error          = (state_q == S_ERROR);

`ifdef FETCH_INSTR_COUNT_EN
  logic [31:0] icnt_q, icnt_d;
  logic        retire;

  // Counter survives flush; only reset clears it
  assign retire = hs && legal_len && !flush;

  always_comb icnt_d = icnt_q + 32'(retire);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) icnt_q <= '0;
    else        icnt_q <= icnt_d;
  end

  assign instr_count = icnt_q;
`else
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_fetch_unescape.sv
// Bench for fetch_unescape: vector table, directed corners,
// and random traffic against a byte-queue reference model.
module tb_fetch_unescape;

  localparam int DEPTH  = 16;
  localparam int WINDOW = 11;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_byte = 8'h00;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  consume_len = 4'd0;
  logic [87:0] unescaped_instr;
  logic        prefix_operand_16bit, prefix_address_16bit;
  logic        prefix_lock, prefix_rep, prefix_repne, is_escaped;
  logic        fetch_error;
  logic [31:0] instr_count;

  fetch_unescape #(.DEPTH(DEPTH), .WINDOW(WINDOW), .MAX_PREFIXES(4)) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .flush                (flush),
    .in_valid             (in_valid),
    .in_ready             (in_ready),
    .in_byte              (in_byte),
    .out_valid            (out_valid),
    .out_ready            (out_ready),
    .consume_len          (consume_len),
    .unescaped_instr      (unescaped_instr),
    .prefix_operand_16bit (prefix_operand_16bit),
    .prefix_address_16bit (prefix_address_16bit),
    .prefix_lock          (prefix_lock),
    .prefix_rep           (prefix_rep),
    .prefix_repne         (prefix_repne),
    .is_escaped           (is_escaped),
    .fetch_error          (fetch_error),
    .instr_count          (instr_count)
  );

  always #5 clk = ~clk;

  wire [5:0] fl = {prefix_operand_16bit, prefix_address_16bit, prefix_lock,
                   prefix_rep, prefix_repne, is_escaped};

  int n_cmp = 0;
  int n_bad = 0;
  int exp_icnt = 0;

  task automatic chk(input string name, input logic [127:0] act,
                     input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] icnt_exp();
`ifdef FETCH_INSTR_COUNT_EN
    return 32'(exp_icnt);
`else
    return 32'd0;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_b(input logic [7:0] b);
    in_valid = 1'b1;
    in_byte  = b;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    tick();
    flush = 1'b0;
  endtask

  task automatic handshake(input logic [3:0] len);
    out_ready   = 1'b1;
    consume_len = len;
    tick();
    out_ready   = 1'b0;
  endtask

  typedef struct {
    logic [47:0] pre;
    int          np;
    logic [7:0]  op;
    logic [5:0]  fl;
    logic        err;
    logic        ov;
  } vec_t;

  // ---- reference model ----
  logic [7:0] mq[$];
  int         mst;
  logic [5:0] mfl;
  int         mnp;

  function automatic logic [5:0] ref_flag(input logic [7:0] b);
    case (b)
      8'h66:   return 6'b100000;
      8'h67:   return 6'b010000;
      8'hF0:   return 6'b001000;
      8'hF3:   return 6'b000100;
      8'hF2:   return 6'b000010;
      default: return 6'b000000;
    endcase
  endfunction

  task automatic model_step(input logic f, input logic iv, input logic [7:0] ib,
                            input logic ordy, input logic [3:0] cl);
    logic       pushok;
    logic [7:0] b;
    logic [5:0] pf;
    if (f) begin
      mq.delete();
      mst = 0;
      mfl = '0;
      mnp = 0;
      return;
    end
    pushok = iv && (mq.size() < DEPTH);
    if (mst == 0) begin
      if (mq.size() > 0) begin
        b  = mq[0];
        pf = ref_flag(b);
        if (pf != 0) begin
          if (mnp == 4) mst = 2;
          else begin
            void'(mq.pop_front());
            mfl = mfl | pf;
            mnp++;
          end
        end else if (b == 8'h0F) begin
          void'(mq.pop_front());
          mfl[0] = 1'b1;
          mst = 1;
        end else begin
          mst = 1;
        end
      end
    end else if (mst == 1) begin
      if (mq.size() >= WINDOW && ordy) begin
        if (cl >= 1 && cl <= WINDOW) begin
          repeat (int'(cl)) void'(mq.pop_front());
          mfl = '0;
          mnp = 0;
          mst = 0;
          exp_icnt++;
        end else begin
          mst = 2;
        end
      end
    end
    if (pushok) mq.push_back(ib);
  endtask

  task automatic rand_cycle();
    logic        f, iv, ordy, eov;
    logic [7:0]  ib;
    logic [3:0]  cl;
    logic [87:0] ew;
    int          r;
    if (mst == 2) f = ($urandom_range(0, 3) == 0);
    else          f = ($urandom_range(0, 199) == 0);
    iv   = ($urandom_range(0, 9) < 7);
    ordy = $urandom_range(0, 1) == 1;
    r    = $urandom_range(0, 9);
    case (r)
      0: ib = 8'h66;
      1: begin
        case ($urandom_range(0, 3))
          0: ib = 8'h67;
          1: ib = 8'hF0;
          2: ib = 8'hF2;
          default: ib = 8'hF3;
        endcase
      end
      2: ib = 8'h0F;
      default: ib = 8'($urandom_range(0, 255));
    endcase
    if ($urandom_range(0, 63) == 0) cl = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(12, 15));
    else cl = 4'($urandom_range(1, 11));
    flush = f; in_valid = iv; in_byte = ib; out_ready = ordy; consume_len = cl;
    #2;
    eov = (mst == 1) && (mq.size() >= WINDOW);
    chk("rnd_in_ready", in_ready, (mq.size() < DEPTH) && !f);
    chk("rnd_out_valid", out_valid, eov);
    chk("rnd_flags", fl, mfl);
    chk("rnd_error", fetch_error, mst == 2);
    chk("rnd_icount", instr_count, icnt_exp());
    if (eov) begin
      ew = '0;
      for (int k = 0; k < WINDOW; k++) ew[8*k +: 8] = mq[k];
      chk("rnd_window", unescaped_instr, ew);
    end
    model_step(f, iv, ib, ordy, cl);
    tick();
  endtask

  vec_t vt[11];
  int   pre_cnt;

  initial begin
    vt[0]  = '{48'h0000_0000_0000, 0, 8'h01, 6'b000000, 1'b0, 1'b1};
    vt[1]  = '{48'h660F_0000_0000, 2, 8'hAF, 6'b100001, 1'b0, 1'b1};
    vt[2]  = '{48'h6700_0000_0000, 1, 8'h8B, 6'b010000, 1'b0, 1'b1};
    vt[3]  = '{48'hF000_0000_0000, 1, 8'h87, 6'b001000, 1'b0, 1'b1};
    vt[4]  = '{48'hF300_0000_0000, 1, 8'hA4, 6'b000100, 1'b0, 1'b1};
    vt[5]  = '{48'hF200_0000_0000, 1, 8'hAE, 6'b000010, 1'b0, 1'b1};
    vt[6]  = '{48'h6666_F3F0_0000, 4, 8'h01, 6'b101100, 1'b0, 1'b1};
    vt[7]  = '{48'h6666_6666_6600, 5, 8'h90, 6'b100000, 1'b1, 1'b0};
    vt[8]  = '{48'h0F00_0000_0000, 1, 8'h0F, 6'b000001, 1'b0, 1'b1};
    vt[9]  = '{48'hF2F3_670F_0000, 4, 8'h38, 6'b010111, 1'b0, 1'b1};
    vt[10] = '{48'h66F0_0F00_0000, 3, 8'h0F, 6'b101001, 1'b0, 1'b1};

    // reset values
    #12;
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_flags", fl, 6'b0);
    chk("rst_error", fetch_error, 1'b0);
    chk("rst_icount", instr_count, 32'd0);
    chk("rst_window", unescaped_instr, 88'd0);
    rst_n = 1'b1;
    tick();

    // table of single instructions
    for (int i = 0; i < 11; i++) begin
      do_flush();
      chk("vec_flush_err", fetch_error, 1'b0);
      chk("vec_flush_cnt", dut.q_count, 5'd0);
      for (int j = 0; j < vt[i].np; j++) push_b(vt[i].pre[47-8*j -: 8]);
      push_b(vt[i].op);
      repeat (10) push_b(8'h90);
      repeat (4) tick();
      chk("vec_flags", fl, vt[i].fl);
      chk("vec_error", fetch_error, vt[i].err);
      chk("vec_out_valid", out_valid, vt[i].ov);
      if (vt[i].ov) begin
        chk("vec_head", unescaped_instr[7:0], vt[i].op);
        handshake(4'd11);
        exp_icnt++;
        chk("vec_drain_cnt", dut.q_count, 5'd0);
        chk("vec_drain_flags", fl, 6'b0);
        chk("vec_icount", instr_count, icnt_exp());
      end
    end

    // window valid exactly when 11 body bytes are queued
    do_flush();
    push_b(8'h01);
    push_b(8'hD8);
    repeat (8) push_b(8'h90);
    chk("b10_out_valid", out_valid, 1'b0);
    push_b(8'h90);
    chk("b11_out_valid", out_valid, 1'b1);
    chk("b11_head", unescaped_instr[7:0], 8'h01);
    chk("b11_count", dut.q_count, 5'd11);
    handshake(4'd2);
    exp_icnt++;
    chk("b_pop2_count", dut.q_count, 5'd9);
    chk("b_pop2_out_valid", out_valid, 1'b0);

    // prefix scan duration with a streaming 66 0F AF
    do_flush();
    pre_cnt = 0;
    for (int i = 0; i < 13; i++) begin
      push_b(i == 0 ? 8'h66 : i == 1 ? 8'h0F : i == 2 ? 8'hAF : 8'h90);
      if (dut.state_q == fetch_pkg::S_PREFIX) pre_cnt++;
    end
    chk("lat_prefix_cycles", 32'(pre_cnt), 32'd2);
    chk("lat_flags", fl, 6'b100001);
    chk("lat_head", unescaped_instr[7:0], 8'hAF);
    chk("lat_out_valid", out_valid, 1'b1);

    // full queue, then pop while a push is blocked
    do_flush();
    for (int i = 0; i < 16; i++) push_b(8'h90 + 8'(i));
    chk("full_count", dut.q_count, 5'd16);
    chk("full_in_ready", in_ready, 1'b0);
    in_valid = 1'b1;
    in_byte  = 8'hAA;
    handshake(4'd3);
    in_valid = 1'b0;
    exp_icnt++;
    chk("full_pop3_count", dut.q_count, 5'd13);
    chk("full_pop3_in_ready", in_ready, 1'b1);

    // illegal consume length
    repeat (2) tick();
    handshake(4'd0);
    chk("len0_error", fetch_error, 1'b1);
    chk("len0_count", dut.q_count, 5'd13);
    chk("len0_icount", instr_count, icnt_exp());
    chk("len0_out_valid", out_valid, 1'b0);

    // flush during prefix scan drops the concurrent push
    do_flush();
    push_b(8'h66);
    flush    = 1'b1;
    in_valid = 1'b1;
    in_byte  = 8'hF3;
    #1;
    chk("flush_in_ready", in_ready, 1'b0);
    tick();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_count", dut.q_count, 5'd0);
    chk("flush_flags", fl, 6'b0);
    chk("flush_state", dut.state_q == fetch_pkg::S_PREFIX, 1'b1);

    // asynchronous reset mid-operation
    push_b(8'h66);
    push_b(8'hF2);
    push_b(8'h01);
    #2;
    rst_n = 1'b0;
    #1;
    exp_icnt = 0;
    chk("arst_count", dut.q_count, 5'd0);
    chk("arst_flags", fl, 6'b0);
    chk("arst_icount", instr_count, 32'd0);
    chk("arst_window", unescaped_instr, 88'd0);
    rst_n = 1'b1;
    tick();

    // random traffic against the model
    mq.delete();
    mst = 0;
    mfl = '0;
    mnp = 0;
    repeat (4000) rand_cycle();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fetch_unescape.md
# fetch_unescape

Byte-stream instruction fetch front end that sits directly upstream of `decode_opnds`. It buffers incoming instruction bytes in a circular queue and strips legacy prefixes (0x66, 0x67, 0xF0, 0xF2, 0xF3) and the 0x0F escape byte into flags. It presents an 11-byte `unescaped_instr` window to the decoder, then pops exactly the number of bytes the decoder reports as consumed.

## Interface
Parameters:
- `DEPTH`, 16: byte-queue capacity (power of two, ≥ WINDOW).
- `WINDOW`, 11: bytes presented to the decoder.
- `MAX_PREFIXES`, 4: legal prefix bytes per instruction.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `flush`  in  1  synchronous queue/state clear (control-flow redirect).
- `in_valid`  in  1  `in_byte` valid.
- `in_ready`  out  1  queue can accept a byte.
- `in_byte`  in  8  next instruction byte, program order.
- `out_valid`  out  1  window and flags valid.
- `out_ready`  in  1  decoder accepts instruction.
- `consume_len`  in  4  bytes after prefixes/escape consumed by decoder (opcode + body), legal 1..WINDOW.
- `unescaped_instr`  out  88  window; head byte in [7:0], byte k in [8k+7:8k].
- `prefix_operand_16bit`, `prefix_address_16bit`, `prefix_lock`, `prefix_rep`, `prefix_repne`, `is_escaped`  out  1 each  flags for the current instruction.
- `fetch_error`  out  1  sticky decode-format error.
- `instr_count`  out  32  retired-instruction count (see Configuration).

## Operation
- The queue holds `head`, `count` (0..DEPTH), and byte storage. Push occurs when `in_valid && in_ready`. `in_ready = count < DEPTH && !flush`.
- State machine states are S_PREFIX, S_BODY and S_ERROR. Reset state is S_PREFIX.
- S_PREFIX, when `count ≥ 1`, examines the head byte:
  - Prefix byte: pop 1, OR the matching flag, increment `pfx_cnt`. If `pfx_cnt` is already MAX_PREFIXES, the byte is not popped; set `fetch_error` and go to S_ERROR.
  - 0x0F: pop 1, set `is_escaped`, go to S_BODY.
  - Any other byte: go to S_BODY without popping.
  - With `count = 0`, the machine holds.
- S_BODY:
  - `out_valid = (count ≥ WINDOW)`.
  - On handshake with `1 ≤ consume_len ≤ WINDOW`: pop `consume_len` bytes, clear all flags and `pfx_cnt`, go to S_PREFIX.
  - On handshake with an illegal `consume_len`: no pop, set `fetch_error`, go to S_ERROR.
- S_ERROR: `out_valid = 0`. The machine holds until `flush`.
- Duplicate prefixes are legal: flags are ORed, and each duplicate counts toward MAX_PREFIXES.
- A 0x0F byte seen after leaving S_PREFIX is body data.
- `flush` takes priority over every other event. It sets `count`, `head`, flags, `pfx_cnt` and `fetch_error` to 0 and the state to S_PREFIX. Any push in that cycle is dropped.
- Count arithmetic: `count_next = count + push − pop`, with pop ≤ count guaranteed by the state conditions. Simultaneous push and pop are legal at any level, including full: a push at full is blocked by `in_ready`, while a pop at full frees space on the next cycle only. Head pointer arithmetic wraps mod DEPTH.

## Timing
- Reset values: all outputs 0 except `in_ready = 1`. `count = 0`, `head = 0`, `instr_count = 0`.
- `in_ready`, `out_valid`, `unescaped_instr` and the flags are combinational from registers only. There is no input-to-output combinational path except `flush` → `in_ready`.
- Latency: an instruction with P prefixes (with or without escape) spends P+1 cycles in S_PREFIX once bytes are present. `out_valid` rises the cycle after that, provided `count ≥ WINDOW`.
- Back-to-back throughput is one instruction per P+2 cycles.
- Reset asserted mid-operation clears all state immediately (asynchronous); outputs take their reset values.

## Configuration
- `FETCH_INSTR_COUNT_EN` defined: `instr_count` increments on every S_BODY handshake with a legal `consume_len`, wraps at 2^32, and clears on reset only (not on `flush`).
- `FETCH_INSTR_COUNT_EN` undefined: the counter register is absent and `instr_count` is tied to 0.

## Structure
- Shared package `fetch_pkg`:
  - state enum `{S_PREFIX, S_BODY, S_ERROR}`;
  - prefix byte constants `PFX_OPSIZE=8'h66`, `PFX_ADDRSIZE=8'h67`, `PFX_LOCK=8'hF0`, `PFX_REPNE=8'hF2`, `PFX_REP=8'hF3`, `ESCAPE_0F=8'h0F`.
- One sub-module `byte_queue`: a circular buffer with push, variable pop (0..WINDOW), `count`, and a WINDOW-byte read port starting at `head`. The FSM and flag registers live in `fetch_unescape`.

## Test plan
- Reset, push 01 D8 + 9 × 90 → `out_valid` = 1 after the 11th push plus 1 cycle; `[7:0]` = 0x01, all flags 0; handshake with `consume_len` = 2 → `count` drops by 2.
- Push 66 0F AF C3 + 9 × 90 → `prefix_operand_16bit` = 1, `is_escaped` = 1, `[7:0]` = 0xAF, S_PREFIX lasts 2 cycles.
- Push 5 × 66 then 90 → `fetch_error` = 1, `out_valid` never asserts; `flush` → `fetch_error` = 0, `count` = 0.
- Push 16 bytes with `out_ready` = 0 → `in_ready` = 0 at `count` = 16. Raise `out_ready` with `consume_len` = 3 while pushing → `count` = 13 next cycle, `in_ready` = 1.
- `flush` asserted with `in_valid` = 1 during a prefix scan → byte dropped, flags 0, state S_PREFIX.
- `consume_len` = 0 on handshake → `fetch_error` = 1, no pop, `instr_count` unchanged (macro defined).
